fft_addr_gen_multistage: RTL and testbench
==========================================

Name: fft_addr_gen_multistage

Overview:
- Radix-2 in-place FFT address generator that sequences all LOG2N stages of one transform from a single start pulse.
- Each cycle it issues one butterfly read pair (a, b) plus a twiddle ROM index, using a valid/ready handshake.
- It delays each accepted pair's addresses by the butterfly latency and replays them as write-back addresses.
- Sits between the data RAM / twiddle ROM and the butterfly unit; replaces the per-stage two-cycle generators.

Parameters:
- LOG2N, 4, log2 of transform size; N = 1<<LOG2N (localparam). Legal range 2..10.
- TW_BITS, 10, twiddle ROM index width; the ROM holds 2^TW_BITS points of a full circle. Must be >= LOG2N.
- BF_LAT, 3, butterfly pipeline latency in cycles. Must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- pair_ready  in  1  butterfly accepts the current pair
- pair_valid  out  1  rd_addr_a/rd_addr_b/tw_addr valid
- rd_addr_a  out  LOG2N  upper butterfly input address
- rd_addr_b  out  LOG2N  lower butterfly input address
- tw_addr  out  TW_BITS  twiddle ROM index
- stage_idx  out  ST_W  current stage 1..LOG2N; ST_W = $clog2(LOG2N+1); 0 when idle
- wr_valid  out  1  write-back pair valid
- wr_addr_a  out  LOG2N  write-back address a
- wr_addr_b  out  LOG2N  write-back address b
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse at transform end

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: all outputs 0, FSM in IDLE, write pipe empty. Reset mid-transform aborts immediately; no done pulse is generated.
- FSM states and transitions:
  - IDLE: start=1 -> RUN, stage=1, j=0.
  - RUN: on the acceptance of the last pair (j = N/2-1 and pair_ready) -> DRAIN.
  - DRAIN: when the write pipe is empty and stage < LOG2N -> RUN with stage+1, j=0. When the pipe is empty and stage = LOG2N -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- Address arithmetic for pair index j in stage s:
  - half = 1<<(s-1); g = j>>(s-1); k = j & (half-1).
  - rd_addr_a = (g<<s)+k; rd_addr_b = rd_addr_a+half.
  - tw_addr = k<<(TW_BITS-s).
  - All values are unsigned; widths are truncated to the port widths (no overflow occurs for legal parameters).
- Handshake:
  - A pair is accepted when pair_valid & pair_ready are both 1 at a clock edge.
  - While pair_valid=1 and pair_ready=0, all read outputs hold stable.
  - Throughput is one pair per cycle when pair_ready stays high.
- Latency:
  - start is sampled at edge 0; the first pair (0,1,tw 0) is valid in the following cycle.
  - Each accepted pair is presented on wr_valid/wr_addr_* exactly BF_LAT cycles after its acceptance edge.
  - The write pipe advances every cycle, independent of pair_ready.
- Stage barrier: no pair of stage s+1 is presented until the cycle after the last wr_valid of stage s.
- busy: high from the cycle after start is accepted through the done cycle inclusive.
- start while busy is ignored; start coincident with done is ignored.
- stage_idx holds its value through DRAIN and returns to 0 in IDLE.

Optional Feature:
- Macro FFT_AGEN_INVERSE_EN.
- Defined: adds input port `inverse` (1 bit), latched on the start edge. When the latched value is 1, tw_addr = (2^TW_BITS - idx) mod 2^TW_BITS, i.e. a conjugate twiddle for the IFFT.
- Undefined: no `inverse` port; tw_addr = idx always.

Decomposition:
- Package fft_agen_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE); function pair_addr(s, j) returning a, b, k; constants for legal parameter bounds.
- Sub-module fft_agen_wr_pipe: a BF_LAT-deep shift register of {valid, addr_a, addr_b}, with an empty flag derived from the OR of its valid bits.

Test Plan:
All scenarios use LOG2N=4, TW_BITS=10, BF_LAT=3.
1. Reset, then start with pair_ready=1:
   - Stage 1 pairs (0,1),(2,3)...(14,15), tw 0.
   - Stage 2 pairs (0,2),(1,3),(4,6)..., tw 0,256,0,256...
   - Stage 4 pairs (0,8)...(7,15), tw 0,64,...,448.
2. pair_ready randomly toggled (50%):
   - Exactly 32 pairs accepted, in the same sequence as scenario 1.
   - Outputs stable during every stall cycle; no drops, no duplicates.
3. Write pipe check:
   - Each wr_valid occurs exactly 3 cycles after its acceptance edge, with matching addresses.
   - The first stage-2 pair_valid is never asserted at or before the last stage-1 wr_valid.
4. Cycle timing with pair_ready=1 and start sampled at edge 0:
   - Stage s pairs occupy cycles 1+11(s-1) through 8+11(s-1).
   - done is high only in cycle 45; busy is low from cycle 46.
5. Reset asserted mid stage 3, then release:
   - All outputs are 0 and the write pipe is empty.
   - start is ignored while busy; a new start restarts cleanly at stage 1, pair (0,1).
6. FFT_AGEN_INVERSE_EN defined, inverse=1:
   - Stage 4 tw sequence is 0,960,896,...,576.
   - A second transform with inverse=0 reverts to 0,64,...,448.

Source files
------------

// File: rtl/fft_agen_pkg.sv
// Shared types and address helper for the multistage radix-2 FFT address generator.
package fft_agen_pkg;

  localparam int LOG2N_MIN  = 2;
  localparam int LOG2N_MAX  = 10;
  localparam int BF_LAT_MIN = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } agen_state_e;

  typedef struct packed {
    logic [LOG2N_MAX-1:0] a;
    logic [LOG2N_MAX-1:0] b;
    logic [LOG2N_MAX-1:0] k;
  } pair_addr_t;

  // Butterfly pair j of stage s (1-based); s=0 yields don't-care values.
  function automatic pair_addr_t pair_addr(input logic [3:0] s, input logic [LOG2N_MAX-1:0] j);
    logic [LOG2N_MAX-1:0] half;
    logic [LOG2N_MAX-1:0] g;
    pair_addr_t           p;
    half = LOG2N_MAX'(1) << (s - 4'd1);
    g    = j >> (s - 4'd1);
    p.k  = j & (half - LOG2N_MAX'(1));
    p.a  = (g << s) + p.k;
    p.b  = p.a + half;
    return p;
  endfunction

endpackage

// File: rtl/fft_agen_wr_pipe.sv
// Fixed-latency delay line that replays accepted read pairs as write-back addresses.
module fft_agen_wr_pipe #(
  parameter int AW    = 4,
  parameter int DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_addr_a_i,
  input  logic [AW-1:0] in_addr_b_i,
  output logic          out_valid_o,
  output logic [AW-1:0] out_addr_a_o,
  output logic [AW-1:0] out_addr_b_o,
  output logic          empty_next_o
);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      a_q[0]     <= in_addr_a_i;
      b_q[0]     <= in_addr_b_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        a_q[i]     <= a_q[i-1];
        b_q[i]     <= b_q[i-1];
      end
    end
  end

  assign out_valid_o  = valid_q[DEPTH-1];
  assign out_addr_a_o = a_q[DEPTH-1];
  assign out_addr_b_o = b_q[DEPTH-1];

  // Pipe will be empty after this edge: only the output slot (if anything) is occupied.
  if (DEPTH == 1) begin : g_shallow
    assign empty_next_o = ~in_valid_i;
  end else begin : g_deep
    assign empty_next_o = ~in_valid_i & ~(|valid_q[DEPTH-2:0]);
  end

endmodule

// File: rtl/fft_addr_gen_multistage.sv
// Radix-2 in-place FFT address generator sequencing all stages from one start pulse.
// Optional conjugate twiddles for IFFT under `define FFT_AGEN_INVERSE_EN.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing read pairs of the current stage
//   ST_DRAIN | waiting for write pipe to empty (stage barrier)
//   ST_DONE  | single-cycle done pulse
module fft_addr_gen_multistage
  import fft_agen_pkg::*;
#(
  parameter  int LOG2N   = 4,
  parameter  int TW_BITS = 10,
  parameter  int BF_LAT  = 3,
  localparam int ST_W    = $clog2(LOG2N + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
`ifdef FFT_AGEN_INVERSE_EN
  input  logic               inverse_i,
`endif
  input  logic               pair_ready_i,
  output logic               pair_valid_o,
  output logic [LOG2N-1:0]   rd_addr_a_o,
  output logic [LOG2N-1:0]   rd_addr_b_o,
  output logic [TW_BITS-1:0] tw_addr_o,
  output logic [ST_W-1:0]    stage_idx_o,
  output logic               wr_valid_o,
  output logic [LOG2N-1:0]   wr_addr_a_o,
  output logic [LOG2N-1:0]   wr_addr_b_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int            J_W    = LOG2N - 1;
  localparam logic [J_W-1:0] J_LAST = {J_W{1'b1}};

  agen_state_e       state_q, state_d;
  logic [ST_W-1:0]   stage_q, stage_d;
  logic [J_W-1:0]    j_q, j_d;
  logic              inv_q, inv_d;

  logic               pair_valid_q, pair_valid_d;
  logic [LOG2N-1:0]   rd_a_q, rd_a_d;
  logic [LOG2N-1:0]   rd_b_q, rd_b_d;
  logic [TW_BITS-1:0] tw_q, tw_d;
  logic [ST_W-1:0]    stage_idx_q, stage_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               pipe_drained;
  pair_addr_t         pa;
  logic [TW_BITS-1:0] tw_raw;

  assign accept = pair_valid_q & pair_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          stage_d = ST_W'(1);
          j_d     = '0;
`ifdef FFT_AGEN_INVERSE_EN
          inv_d   = inverse_i;
`else
          inv_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (j_q == J_LAST) state_d = ST_DRAIN;
          else               j_d     = j_q + J_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pipe_drained) begin
          if (stage_q == ST_W'(LOG2N)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + ST_W'(1);
            j_d     = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next-state values.
  always_comb begin
    pa           = pair_addr(4'(stage_d), LOG2N_MAX'(j_d));
    tw_raw       = TW_BITS'(pa.k) << (TW_BITS - int'(stage_d));
    pair_valid_d = (state_d == ST_RUN);
    rd_a_d       = '0;
    rd_b_d       = '0;
    tw_d         = '0;
    if (pair_valid_d) begin
      rd_a_d = LOG2N'(pa.a);
      rd_b_d = LOG2N'(pa.b);
      tw_d   = inv_d ? (-tw_raw) : tw_raw;
    end
    stage_idx_d = (state_d == ST_IDLE) ? '0 : stage_d;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_valid_q <= 1'b0;
      rd_a_q       <= '0;
      rd_b_q       <= '0;
      tw_q         <= '0;
      stage_idx_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pair_valid_q <= pair_valid_d;
      rd_a_q       <= rd_a_d;
      rd_b_q       <= rd_b_d;
      tw_q         <= tw_d;
      stage_idx_q  <= stage_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  fft_agen_wr_pipe #(
    .AW    (LOG2N),
    .DEPTH (BF_LAT)
  ) u_wr_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (accept),
    .in_addr_a_i  (rd_a_q),
    .in_addr_b_i  (rd_b_q),
    .out_valid_o  (wr_valid_o),
    .out_addr_a_o (wr_addr_a_o),
    .out_addr_b_o (wr_addr_b_o),
    .empty_next_o (pipe_drained)
  );

  assign pair_valid_o = pair_valid_q;
  assign rd_addr_a_o  = rd_a_q;
  assign rd_addr_b_o  = rd_b_q;
  assign tw_addr_o    = tw_q;
  assign stage_idx_o  = stage_idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_fft_addr_gen_multistage.sv
// Self-checking bench for fft_addr_gen_multistage (LOG2N=4, TW_BITS=10, BF_LAT=3).
module tb_fft_addr_gen_multistage;

  localparam int LOG2N   = 4;
  localparam int TW_BITS = 10;
  localparam int BF_LAT  = 3;
  localparam int N       = 1 << LOG2N;
  localparam int NP      = LOG2N * N / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pair_ready = 1'b0;
`ifdef FFT_AGEN_INVERSE_EN
  logic       inverse = 1'b0;
`endif
  logic       pair_valid;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [9:0] tw_addr;
  logic [2:0] stage_idx;
  logic       wr_valid;
  logic [3:0] wr_addr_a, wr_addr_b;
  logic       busy, done;

  int checks = 0;
  int failures = 0;

  int m_a[$], m_b[$], m_tw[$], m_st[$];
  int g_acc_a[$], g_acc_b[$], g_acc_tw[$], g_acc_st[$], g_acc_cyc[$];
  int g_wr_a[$], g_wr_b[$], g_wr_cyc[$];

  typedef struct {
    int s; int j; int a; int b; int tw; int cyc;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  fft_addr_gen_multistage #(
    .LOG2N   (LOG2N),
    .TW_BITS (TW_BITS),
    .BF_LAT  (BF_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
`ifdef FFT_AGEN_INVERSE_EN
    .inverse_i    (inverse),
`endif
    .pair_ready_i (pair_ready),
    .pair_valid_o (pair_valid),
    .rd_addr_a_o  (rd_addr_a),
    .rd_addr_b_o  (rd_addr_b),
    .tw_addr_o    (tw_addr),
    .stage_idx_o  (stage_idx),
    .wr_valid_o   (wr_valid),
    .wr_addr_a_o  (wr_addr_a),
    .wr_addr_b_o  (wr_addr_b),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: stage s pairs every address a whose bit (s-1) is clear with a+half, ascending.
  task automatic build_model(input bit inv);
    m_a.delete(); m_b.delete(); m_tw.delete(); m_st.delete();
    for (int s = 1; s <= LOG2N; s++) begin
      int half;
      half = 1 << (s - 1);
      for (int a = 0; a < N; a++) begin
        if (((a / half) % 2) == 0) begin
          int t;
          t = (a % half) * ((1 << TW_BITS) / (2 * half));
          if (inv) t = ((1 << TW_BITS) - t) % (1 << TW_BITS);
          m_a.push_back(a); m_b.push_back(a + half); m_tw.push_back(t); m_st.push_back(s);
        end
      end
    end
  endtask

  task automatic run_xform(input bit rand_ready, input bit inv, input bit start_noise,
                           input bit check_timing, input string tag);
    int   cyc, done_cnt, done_at, busy_low_at, r;
    bit   finished, prev_stall;
    logic [3:0] pa_prev, pb_prev;
    logic [9:0] tw_prev;
    logic [2:0] st_prev;
    int   first_pv[LOG2N+1];
    int   last_wr[LOG2N+1];
    logic idle_pv;
    logic [2:0] idle_st;

    build_model(inv);
    g_acc_a.delete(); g_acc_b.delete(); g_acc_tw.delete(); g_acc_st.delete(); g_acc_cyc.delete();
    g_wr_a.delete(); g_wr_b.delete(); g_wr_cyc.delete();
    for (int s = 0; s <= LOG2N; s++) begin first_pv[s] = -1; last_wr[s] = -1; end
    done_cnt = 0; done_at = -1; busy_low_at = -1; finished = 0; prev_stall = 0;
    pa_prev = '0; pb_prev = '0; tw_prev = '0; st_prev = '0; idle_pv = 1'b1; idle_st = '1;

    @(negedge clk);
    start = 1'b1;
`ifdef FFT_AGEN_INVERSE_EN
    inverse = inv;
`endif
    pair_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 400) begin
      if (prev_stall) begin
        chk($sformatf("%s stall_hold c%0d", tag, cyc),
            {pair_valid, rd_addr_a, rd_addr_b, tw_addr, stage_idx},
            {1'b1, pa_prev, pb_prev, tw_prev, st_prev});
      end
      if (pair_valid && first_pv[int'(stage_idx)] < 0) first_pv[int'(stage_idx)] = cyc;
      if (wr_valid) begin
        g_wr_a.push_back(int'(wr_addr_a)); g_wr_b.push_back(int'(wr_addr_b)); g_wr_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_at = cyc; end
      if (!busy) begin
        busy_low_at = cyc; finished = 1; idle_pv = pair_valid; idle_st = stage_idx;
      end
      r = rand_ready ? int'($urandom_range(0, 1)) : 1;
      pair_ready = r[0];
      start = (start_noise && busy) ? ($urandom_range(0, 1) == 1 || done) : 1'b0;
      if (pair_valid && r[0]) begin
        g_acc_a.push_back(int'(rd_addr_a)); g_acc_b.push_back(int'(rd_addr_b));
        g_acc_tw.push_back(int'(tw_addr)); g_acc_st.push_back(int'(stage_idx));
        g_acc_cyc.push_back(cyc);
      end
      prev_stall = pair_valid && !r[0];
      pa_prev = rd_addr_a; pb_prev = rd_addr_b; tw_prev = tw_addr; st_prev = stage_idx;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    pair_ready = 1'b0;

    chk({tag, " finished"}, finished, 1);
    chk({tag, " pairs_accepted"}, g_acc_a.size(), NP);
    chk({tag, " wr_count"}, g_wr_a.size(), NP);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " busy_low_after_done"}, busy_low_at, done_at + 1);
    chk({tag, " idle_valid_stage"}, {idle_pv, idle_st}, 4'b0);
    for (int i = 0; i < NP && i < g_acc_a.size(); i++) begin
      chk($sformatf("%s pair%0d {a,b,tw,st}", tag, i),
          {16'(g_acc_a[i]), 16'(g_acc_b[i]), 16'(g_acc_tw[i]), 16'(g_acc_st[i])},
          {16'(m_a[i]), 16'(m_b[i]), 16'(m_tw[i]), 16'(m_st[i])});
      if (i < g_wr_a.size()) begin
        chk($sformatf("%s wr%0d {cyc,a,b}", tag, i),
            {32'(g_wr_cyc[i]), 16'(g_wr_a[i]), 16'(g_wr_b[i])},
            {32'(g_acc_cyc[i] + BF_LAT), 16'(g_acc_a[i]), 16'(g_acc_b[i])});
        last_wr[m_st[i]] = g_wr_cyc[i];
      end
      if (check_timing)
        chk($sformatf("%s pair%0d cycle", tag, i), g_acc_cyc[i],
            1 + 11 * (m_st[i] - 1) + (i % (N / 2)));
    end
    for (int s = 2; s <= LOG2N; s++)
      chk($sformatf("%s barrier_s%0d", tag, s), first_pv[s] > last_wr[s-1], 1);
    if (check_timing) begin
      chk({tag, " done_cycle"}, done_at, 45);
      chk({tag, " busy_low_cycle"}, busy_low_at, 46);
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 1, 0, 1};
    vecs[1] = '{1, 7, 14, 15, 0, 8};
    vecs[2] = '{2, 0, 0, 2, 0, 12};
    vecs[3] = '{2, 1, 1, 3, 256, 13};
    vecs[4] = '{2, 2, 4, 6, 0, 14};
    vecs[5] = '{3, 3, 3, 7, 384, 26};
    vecs[6] = '{3, 5, 9, 13, 128, 28};
    vecs[7] = '{4, 0, 0, 8, 0, 34};
    vecs[8] = '{4, 1, 1, 9, 64, 35};
    vecs[9] = '{4, 7, 7, 15, 448, 41};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {pair_valid, rd_addr_a, rd_addr_b, tw_addr, stage_idx, wr_valid, wr_addr_a, wr_addr_b, busy, done},
        '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_xform(1'b0, 1'b0, 1'b0, 1'b1, "full_rate");
    for (int v = 0; v < 10; v++) begin
      int idx;
      idx = (vecs[v].s - 1) * (N / 2) + vecs[v].j;
      if (idx < g_acc_a.size())
        chk($sformatf("vec%0d s%0d j%0d {a,b,tw,cyc}", v, vecs[v].s, vecs[v].j),
            {16'(g_acc_a[idx]), 16'(g_acc_b[idx]), 16'(g_acc_tw[idx]), 16'(g_acc_cyc[idx])},
            {16'(vecs[v].a), 16'(vecs[v].b), 16'(vecs[v].tw), 16'(vecs[v].cyc)});
      else
        chk($sformatf("vec%0d present", v), g_acc_a.size(), idx + 1);
    end

    run_xform(1'b1, 1'b0, 1'b1, 1'b0, "rand_ready_a");
    run_xform(1'b1, 1'b0, 1'b1, 1'b0, "rand_ready_b");

    begin
      bit   reached;
      logic any_act;
      reached = 0;
      @(negedge clk);
      start = 1'b1;
      pair_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && !reached; c++) begin
        if (stage_idx == 3'd3 && pair_valid) reached = 1;
        else @(negedge clk);
      end
      chk("reach_stage3", reached, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_outputs",
          {pair_valid, rd_addr_a, rd_addr_b, tw_addr, stage_idx, wr_valid, wr_addr_a, wr_addr_b, busy, done},
          '0);
      @(negedge clk);
      rst_n = 1'b1;
      any_act = 1'b0;
      for (int c = 0; c < BF_LAT + 3; c++) begin
        @(negedge clk);
        any_act = any_act | wr_valid | pair_valid | busy | done;
      end
      chk("post_reset_quiet", any_act, 1'b0);
      pair_ready = 1'b0;
    end

    run_xform(1'b0, 1'b0, 1'b0, 1'b1, "restart");

`ifdef FFT_AGEN_INVERSE_EN
    run_xform(1'b1, 1'b1, 1'b0, 1'b0, "inverse");
    for (int j = 0; j < N / 2 && 3 * (N / 2) + j < g_acc_tw.size(); j++)
      chk($sformatf("inv_s4_tw%0d", j), g_acc_tw[3 * (N / 2) + j], (1024 - 64 * j) % 1024);
    run_xform(1'b0, 1'b0, 1'b0, 1'b1, "forward_again");
    for (int j = 0; j < N / 2 && 3 * (N / 2) + j < g_acc_tw.size(); j++)
      chk($sformatf("fwd_s4_tw%0d", j), g_acc_tw[3 * (N / 2) + j], 64 * j);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
